// File: rtl/led_flow.sv
// LED pattern sequencer: advances an LED pattern by one step on every edge
// of the upstream toggling tick while enabled. Supports rotate-left,
// rotate-right, ping-pong and blink-all patterns, and keeps a wrapping count
// of accepted steps.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | after reset, no pattern loaded; next step loads from mode
// RUN_L | single lit LED travelling towards the MSB
// RUN_R | single lit LED travelling towards bit 0
// BLINK | all LEDs toggling together between all-on and all-off
module led_flow #(
  parameter int LED_W = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             tick_in,
  input  logic             en,
  input  logic [1:0]       mode,
  output logic [LED_W-1:0] led_out,
  output logic             step_pulse,
  output logic [7:0]       step_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN_L = 2'd1;
  localparam logic [1:0] RUN_R = 2'd2;
  localparam logic [1:0] BLINK = 2'd3;

  localparam logic [1:0] MODE_ROTL  = 2'b00;
  localparam logic [1:0] MODE_ROTR  = 2'b01;
  localparam logic [1:0] MODE_PING  = 2'b10;

  localparam logic [LED_W-1:0] ONE_LSB  = {{(LED_W-1){1'b0}}, 1'b1};
  localparam logic [LED_W-1:0] ONE_MSB  = ONE_LSB << (LED_W - 1);
  // Ping-pong turnarounds skip the end LED so it is not lit twice in a row.
  localparam logic [LED_W-1:0] PING_R_START = ONE_LSB << (LED_W - 2);
  localparam logic [LED_W-1:0] PING_L_START = ONE_LSB << 1;
  localparam logic [LED_W-1:0] ALL_ON   = {LED_W{1'b1}};

  logic             tick_d;
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [1:0]       mode_q;
  logic [LED_W-1:0] led_nxt;
  logic             step;
  logic             load;

  // Any level change of the tick is a step request; requests while disabled are dropped.
  assign step = (tick_in != tick_d) && en;
  assign load = (state == IDLE) || (mode != mode_q);

  // Next pattern and state for a step; only committed when step is true.
  always_comb begin
    led_nxt   = led_out;
    state_nxt = state;
    if (load) begin
      case (mode)
        MODE_ROTL, MODE_PING: begin
          led_nxt   = ONE_LSB;
          state_nxt = RUN_L;
        end
        MODE_ROTR: begin
          led_nxt   = ONE_MSB;
          state_nxt = RUN_R;
        end
        default: begin
          led_nxt   = ALL_ON;
          state_nxt = BLINK;
        end
      endcase
    end else begin
      case (mode)
        MODE_ROTL: begin
          led_nxt   = {led_out[LED_W-2:0], led_out[LED_W-1]};
          state_nxt = RUN_L;
        end
        MODE_ROTR: begin
          led_nxt   = {led_out[0], led_out[LED_W-1:1]};
          state_nxt = RUN_R;
        end
        MODE_PING: begin
          if (state == RUN_R) begin
            if (led_out[0]) begin
              led_nxt   = PING_L_START;
              state_nxt = RUN_L;
            end else begin
              led_nxt = led_out >> 1;
            end
          end else begin
            if (led_out[LED_W-1]) begin
              led_nxt   = PING_R_START;
              state_nxt = RUN_R;
            end else begin
              led_nxt = led_out << 1;
            end
          end
        end
        default: begin
          led_nxt   = ~led_out;
          state_nxt = BLINK;
        end
      endcase
    end
  end

  // Tick history is tracked every cycle so disabled edges are consumed, not queued.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) tick_d <= 1'b0;
    else         tick_d <= tick_in;
  end

  // Pattern, state, mode snapshot and step count all advance together on a step.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      led_out    <= '0;
      state      <= IDLE;
      mode_q     <= 2'b00;
      step_cnt   <= 8'd0;
      step_pulse <= 1'b0;
    end else begin
      step_pulse <= step;
      if (step) begin
        led_out  <= led_nxt;
        state    <= state_nxt;
        mode_q   <= mode;
        step_cnt <= step_cnt + 8'd1;
      end
    end
  end

endmodule
